// File: rtl/bcd_step_counter.sv
// Multi-digit BCD up/down counter with a step prescaler, clear/load, wrap or saturate mode.
// Digits are stored in BCD and stepped by a per-digit carry/borrow ripple, with no divide or modulo logic.
module bcd_step_counter #(
   parameter int NUM_DIGITS = 4,
   parameter int STEP_TIME  = 12000000,
   parameter int PRESCALE_W = 24,
   parameter bit SATURATE   = 1'b0
) (
   input  logic                    sysclk,
   input  logic                    sysrst_n,
   input  logic                    en,
   input  logic                    up_dn,
   input  logic                    clear,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic                    tick,
   output logic                    rollover
);
   localparam int W = 4*NUM_DIGITS;
   localparam logic [PRESCALE_W-1:0] PC_LAST = PRESCALE_W'(STEP_TIME-1);

   logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
   logic [W-1:0]          digits_q, digits_d;
   logic                  tick_q, tick_d;
   logic                  rollover_q, rollover_d;
   logic                  step;
   logic [W:0]            stepped;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   function automatic logic [W-1:0] clamp_word(input logic [W-1:0] w);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_DIGITS; i++) r[4*i +: 4] = clamp_digit(w[4*i +: 4]);
      return r;
   endfunction

   // Result is {carry/borrow out of the top digit, stepped word}.
   function automatic logic [W:0] bcd_step(input logic [W-1:0] w, input logic up);
      logic [W-1:0] r;
      logic         c;
      logic [3:0]   d;
      r = '0;
      c = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         d = clamp_digit(w[4*i +: 4]);
         if (!c) begin
            r[4*i +: 4] = d;
         end else if (up) begin
            if (d == 4'd9) r[4*i +: 4] = 4'd0;
            else begin
               r[4*i +: 4] = d + 4'd1;
               c = 1'b0;
            end
         end else begin
            if (d == 4'd0) r[4*i +: 4] = 4'd9;
            else begin
               r[4*i +: 4] = d - 4'd1;
               c = 1'b0;
            end
         end
      end
      return {c, r};
   endfunction

   always_comb begin
      pcnt_d     = pcnt_q;
      digits_d   = digits_q;
      tick_d     = 1'b0;
      rollover_d = 1'b0;
      step       = en && (pcnt_q == PC_LAST);
      stepped    = bcd_step(digits_q, up_dn);
      if (clear) begin
         digits_d = '0;
         pcnt_d   = '0;
      end else if (load) begin
         digits_d = clamp_word(load_value);
         pcnt_d   = '0;
      end else if (en) begin
         if (step) begin
            pcnt_d     = '0;
            tick_d     = 1'b1;
            rollover_d = stepped[W];
            // A saturated limit step still ticks but leaves the digits unchanged.
            digits_d   = (stepped[W] && SATURATE) ? clamp_word(digits_q) : stepped[W-1:0];
         end else begin
            pcnt_d = pcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge sysclk or negedge sysrst_n) begin
      if (!sysrst_n) begin
         pcnt_q     <= '0;
         digits_q   <= '0;
         tick_q     <= 1'b0;
         rollover_q <= 1'b0;
      end else begin
         pcnt_q     <= pcnt_d;
         digits_q   <= digits_d;
         tick_q     <= tick_d;
         rollover_q <= rollover_d;
      end
   end

   assign digits   = digits_q;
   assign tick     = tick_q;
   assign rollover = rollover_q;
endmodule

// File: tb/tb_bcd_step_counter.sv
// Directed bench: wrap and saturate counters at STEP_TIME=4 sharing stimulus, plus a STEP_TIME=1 full sweep.
module tb_bcd_step_counter;
   logic        clk = 1'b0;
   logic        rst_n, en, up_dn, clear, load;
   logic [15:0] load_value;
   logic        en_f;
   logic        zero = 1'b0;
   logic        one  = 1'b1;
   logic [15:0] zv   = 16'h0000;
   logic [15:0] d_w, d_s, d_f;
   logic        t_w, t_s, t_f, r_w, r_s, r_f;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   bcd_step_counter #(.NUM_DIGITS(4), .STEP_TIME(4), .PRESCALE_W(3), .SATURATE(1'b0)) u_wrap (
      .sysclk(clk), .sysrst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
      .load_value(load_value), .digits(d_w), .tick(t_w), .rollover(r_w));

   bcd_step_counter #(.NUM_DIGITS(4), .STEP_TIME(4), .PRESCALE_W(3), .SATURATE(1'b1)) u_sat (
      .sysclk(clk), .sysrst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
      .load_value(load_value), .digits(d_s), .tick(t_s), .rollover(r_s));

   bcd_step_counter #(.NUM_DIGITS(4), .STEP_TIME(1), .PRESCALE_W(1), .SATURATE(1'b0)) u_fast (
      .sysclk(clk), .sysrst_n(rst_n), .en(en_f), .up_dn(one), .clear(zero), .load(zero),
      .load_value(zv), .digits(d_f), .tick(t_f), .rollover(r_f));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [15:0] v);
      load = 1'b1;
      load_value = v;
      cyc(1);
      load = 1'b0;
   endtask

   initial begin
      int  rolls;
      logic seen;
      rst_n = 1'b0; en = 1'b1; up_dn = 1'b1; clear = 1'b0; load = 1'b0;
      load_value = 16'h0000; en_f = 1'b0;
      #2;
      chk("rst_digits", d_w, 16'h0000);
      chk("rst_tick", t_w, 0);
      chk("rst_roll", r_w, 0);
      cyc(1);
      rst_n = 1'b1;

      // First step arrives on the 4th enabled edge after release.
      for (int i = 1; i <= 3; i++) begin
         cyc(1);
         chk("pre_step_digits", d_w, 16'h0000);
         chk("pre_step_tick", t_w, 0);
      end
      cyc(1);
      chk("step1_digits", d_w, 16'h0001);
      chk("step1_tick", t_w, 1);
      cyc(1);
      chk("tick_pulse_end", t_w, 0);
      cyc(3);
      chk("step2_digits", d_w, 16'h0002);
      chk("step2_tick", t_w, 1);

      // Carry ripple
      do_load(16'h0999);
      chk("load_0999", d_w, 16'h0999);
      chk("load_no_tick", t_w, 0);
      cyc(3);
      chk("hold_0999", d_w, 16'h0999);
      cyc(1);
      chk("ripple_1000", d_w, 16'h1000);
      chk("ripple_tick", t_w, 1);
      chk("ripple_noroll", r_w, 0);
      chk("sat_ripple_1000", d_s, 16'h1000);

      do_load(16'h9999);
      cyc(4);
      chk("wrap_up_digits", d_w, 16'h0000);
      chk("wrap_up_roll", r_w, 1);
      chk("sat_up_digits", d_s, 16'h9999);
      chk("sat_up_roll", r_s, 1);
      chk("sat_up_tick", t_s, 1);
      cyc(1);
      chk("roll_pulse_end", r_w, 0);

      // Down and borrow
      up_dn = 1'b0;
      do_load(16'h1000);
      cyc(4);
      chk("borrow_0999", d_w, 16'h0999);
      chk("borrow_noroll", r_w, 0);
      do_load(16'h0000);
      cyc(4);
      chk("wrap_dn_digits", d_w, 16'h9999);
      chk("wrap_dn_roll", r_w, 1);
      chk("sat_dn_digits", d_s, 16'h0000);
      chk("sat_dn_roll", r_s, 1);
      chk("sat_dn_tick", t_s, 1);

      // clear + load on the terminal prescaler cycle
      cyc(3);
      clear = 1'b1; load = 1'b1; load_value = 16'h1234; up_dn = 1'b1;
      cyc(1);
      clear = 1'b0; load = 1'b0;
      chk("clr_pri_digits", d_w, 16'h0000);
      chk("clr_pri_tick", t_w, 0);
      cyc(3);
      chk("clr_restart_hold", d_w, 16'h0000);
      chk("clr_restart_notick", t_w, 0);
      cyc(1);
      chk("clr_restart_step", d_w, 16'h0001);
      chk("clr_restart_tick", t_w, 1);

      // Nibble clamping
      do_load(16'hA5F3);
      chk("clamp_digits", d_w, 16'h9593);
      chk("clamp_sat_digits", d_s, 16'h9593);

      // Enable gating on the terminal cycle
      cyc(3);
      en = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         seen = seen | t_w;
      end
      chk("gate_no_tick", seen, 0);
      chk("gate_frozen", d_w, 16'h9593);
      en = 1'b1;
      cyc(1);
      chk("gate_resume_digits", d_w, 16'h9594);
      chk("gate_resume_tick", t_w, 1);

      // Async reset between edges while tick is high
      do_load(16'h0041);
      cyc(4);
      chk("pre_arst_digits", d_w, 16'h0042);
      chk("pre_arst_tick", t_w, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_digits", d_w, 16'h0000);
      chk("arst_tick", t_w, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(3);
      chk("post_arst_hold", d_w, 16'h0000);
      cyc(1);
      chk("post_arst_step", d_w, 16'h0001);

      // STEP_TIME=1 sweep: one rollover per 10000 cycles
      en = 1'b0;
      en_f = 1'b1;
      rolls = 0;
      for (int i = 1; i <= 10000; i++) begin
         cyc(1);
         if (r_f) rolls++;
         if (i == 1234) chk("sweep_1234", d_f, 16'h1234);
         if (i == 9999) begin
            chk("sweep_9999", d_f, 16'h9999);
            chk("sweep_9999_noroll", rolls, 0);
         end
      end
      chk("sweep_wrap_digits", d_f, 16'h0000);
      chk("sweep_wrap_roll", r_f, 1);
      chk("sweep_wrap_tick", t_f, 1);
      chk("sweep_roll_count", rolls, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
